// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned INST_W_DEF = 32;
    localparam logic [INST_W_DEF-1:0] NOP_INST_DEF = '0;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry {pc, inst} holding register used to absorb an ID stall.
module fetch_skid
    import fetch_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned INST_W = INST_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0] inst_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [INST_W-1:0] inst_q;

    // Capture on load; clear has priority so a flushed entry never lingers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q   <= '0;
            inst_q <= '0;
        end else if (clear_i) begin
            pc_q   <= '0;
            inst_q <= '0;
        end else if (load_i) begin
            pc_q   <= pc_i;
            inst_q <= inst_i;
        end
    end

    assign pc_o   = pc_q;
    assign inst_o = inst_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack, skids on stall,
// and drains the outstanding request after a redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned        ADDR_W   = ADDR_W_DEF,
    parameter int unsigned        INST_W   = INST_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        PC_STEP  = 1,
    parameter logic [INST_W-1:0]  NOP_INST = NOP_INST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc_out,
    output logic [INST_W-1:0] inst_out,
    output logic              valid_out
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [INST_W-1:0] inst_out_q, inst_out_d;
    logic              valid_out_q, valid_out_d;

    logic              skid_load, skid_clear;
    logic [ADDR_W-1:0] skid_pc;
    logic [INST_W-1:0] skid_inst;

    fetch_skid #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_skid (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (pc_q),
        .inst_i  (imem_rdata),
        .pc_o    (skid_pc),
        .inst_o  (skid_inst)
    );

    // State, PC and registered pipeline outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            pc_out_q     <= RESET_PC;
            inst_out_q   <= NOP_INST;
            valid_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            pc_out_q     <= pc_out_d;
            inst_out_q   <= inst_out_d;
            valid_out_q  <= valid_out_d;
        end
    end

    // Next-state, PC update and output selection; redirect beats stall.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        pc_out_d     = pc_out_q;
        inst_out_d   = inst_out_q;
        valid_out_d  = valid_out_q;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;

        unique case (state_q)
            REQ: begin
                if (redirect_valid) begin
                    valid_out_d = 1'b0;
                    inst_out_d  = NOP_INST;
                    pc_d        = redirect_pc;
                    if (!imem_ack) begin
                        // Request to the old PC is still in flight; finish it.
                        drain_addr_d = pc_q;
                        state_d      = DRAIN;
                    end
                end else if (imem_ack && !stall) begin
                    pc_out_d    = pc_q;
                    inst_out_d  = imem_rdata;
                    valid_out_d = 1'b1;
                    pc_d        = pc_q + ADDR_W'(PC_STEP);
                end else if (imem_ack) begin
                    skid_load = 1'b1;
                    pc_d      = pc_q + ADDR_W'(PC_STEP);
                    state_d   = HOLD;
                end else if (!stall) begin
                    valid_out_d = 1'b0;
                    inst_out_d  = NOP_INST;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    skid_clear  = 1'b1;
                    valid_out_d = 1'b0;
                    inst_out_d  = NOP_INST;
                    pc_d        = redirect_pc;
                    state_d     = REQ;
                end else if (!stall) begin
                    pc_out_d    = skid_pc;
                    inst_out_d  = skid_inst;
                    valid_out_d = 1'b1;
                    state_d     = REQ;
                end
            end
            DRAIN: begin
                valid_out_d = 1'b0;
                inst_out_d  = NOP_INST;
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    assign imem_req  = !rst && (state_q != HOLD);
    assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign pc_out    = pc_out_q;
    assign inst_out  = inst_out_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        valid_out;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_out         (pc_out),
        .inst_out       (inst_out),
        .valid_out      (valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_valid;
    } vec_t;

    vec_t vecs[32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic ack, input logic [31:0] rd, input logic st,
                        input logic rv, input logic [31:0] rpc, input logic req,
                        input logic [31:0] addr, input logic [31:0] pc,
                        input logic [31:0] inst, input logic vld);
        vecs[i] = '{ack, rd, st, rv, rpc, req, addr, pc, inst, vld};
    endtask

    initial begin
        // ack rdata stall rv rpc | req addr | pc_out inst_out valid_out
        setv(0,  1, 32'h100, 0, 0, 0,   1, 32'h0,  32'h0,  32'h100, 1);
        setv(1,  1, 32'h101, 0, 0, 0,   1, 32'h1,  32'h1,  32'h101, 1);
        setv(2,  1, 32'h102, 0, 0, 0,   1, 32'h2,  32'h2,  32'h102, 1);
        setv(3,  1, 32'h103, 0, 0, 0,   1, 32'h3,  32'h3,  32'h103, 1);
        setv(4,  1, 32'h104, 0, 0, 0,   1, 32'h4,  32'h4,  32'h104, 1);
        // stall as pc=5 is acked: skid, then hold two more cycles
        setv(5,  1, 32'h105, 1, 0, 0,   1, 32'h5,  32'h4,  32'h104, 1);
        setv(6,  1, 32'h106, 1, 0, 0,   0, 32'h6,  32'h4,  32'h104, 1);
        setv(7,  1, 32'h106, 1, 0, 0,   0, 32'h6,  32'h4,  32'h104, 1);
        setv(8,  1, 32'hdead, 0, 0, 0,  0, 32'h6,  32'h5,  32'h105, 1);
        setv(9,  1, 32'h106, 0, 0, 0,   1, 32'h6,  32'h6,  32'h106, 1);
        // redirect with ack high at pc=7
        setv(10, 1, 32'h107, 0, 1, 32'h40, 1, 32'h7, 32'h6, 32'h0, 0);
        setv(11, 1, 32'h140, 0, 0, 0,   1, 32'h40, 32'h40, 32'h140, 1);
        setv(12, 1, 32'h141, 0, 1, 32'h9, 1, 32'h41, 32'h40, 32'h0, 0);
        // redirect at pc=9 with ack withheld: drain address 9
        setv(13, 0, 32'h0,   0, 1, 32'h80, 1, 32'h9, 32'h40, 32'h0, 0);
        setv(14, 0, 32'h0,   0, 0, 0,   1, 32'h9,  32'h40, 32'h0,   0);
        setv(15, 0, 32'h0,   0, 0, 0,   1, 32'h9,  32'h40, 32'h0,   0);
        setv(16, 1, 32'h109, 0, 0, 0,   1, 32'h9,  32'h40, 32'h0,   0);
        setv(17, 1, 32'h180, 0, 0, 0,   1, 32'h80, 32'h80, 32'h180, 1);
        // enter HOLD, then redirect+stall together
        setv(18, 1, 32'h181, 1, 0, 0,   1, 32'h81, 32'h80, 32'h180, 1);
        setv(19, 0, 32'h0,   1, 1, 32'h20, 0, 32'h82, 32'h80, 32'h0, 0);
        setv(20, 1, 32'h120, 0, 0, 0,   1, 32'h20, 32'h20, 32'h120, 1);
        // no ack: bubble; stall on bubble holds bubble
        setv(21, 0, 32'h0,   0, 0, 0,   1, 32'h21, 32'h20, 32'h0,   0);
        setv(22, 0, 32'h0,   1, 0, 0,   1, 32'h21, 32'h20, 32'h0,   0);
        setv(23, 1, 32'h121, 0, 0, 0,   1, 32'h21, 32'h21, 32'h121, 1);
        setv(24, 0, 32'h0,   1, 0, 0,   1, 32'h22, 32'h21, 32'h121, 1);
        // redirect, then second redirect in DRAIN overwrites target
        setv(25, 0, 32'h0,   0, 1, 32'h30, 1, 32'h22, 32'h21, 32'h0, 0);
        setv(26, 0, 32'h0,   0, 1, 32'h50, 1, 32'h22, 32'h21, 32'h0, 0);
        setv(27, 1, 32'h122, 0, 0, 0,   1, 32'h22, 32'h21, 32'h0,   0);
        setv(28, 1, 32'h150, 0, 0, 0,   1, 32'h50, 32'h50, 32'h150, 1);
        // PC wrap at top of address space
        setv(29, 1, 32'h151, 0, 1, 32'hffffffff, 1, 32'h51, 32'h50, 32'h0, 0);
        setv(30, 1, 32'haaaa, 0, 0, 0,  1, 32'hffffffff, 32'hffffffff, 32'haaaa, 1);
        setv(31, 1, 32'h100, 0, 0, 0,   1, 32'h0,  32'h0,  32'h100, 1);

        // Reset state
        #2;
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_inst", inst_out, 32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            imem_ack       = vecs[i].ack;
            imem_rdata     = vecs[i].rdata;
            stall          = vecs[i].stall;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            #1;
            check($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pc", i), pc_out, vecs[i].e_pc);
            check($sformatf("v%0d_inst", i), inst_out, vecs[i].e_inst);
            check($sformatf("v%0d_valid", i), 32'(valid_out), 32'(vecs[i].e_valid));
            @(negedge clk);
        end

        // Async reset mid-request with ack low (pc=1 outstanding)
        imem_ack       = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("mid_req_before", 32'(imem_req), 32'h1);
        check("mid_addr_before", imem_addr, 32'h1);
        rst = 1'b1;
        #1;
        check("async_pc", pc_out, 32'h0);
        check("async_inst", inst_out, 32'h0);
        check("async_valid", 32'(valid_out), 32'h0);
        check("async_req", 32'(imem_req), 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hbad;
        @(posedge clk);
        #1;
        check("rst_hold_valid", 32'(valid_out), 32'h0);
        @(negedge clk);
        rst        = 1'b0;
        imem_rdata = 32'h100;
        #1;
        check("post_rst_req", 32'(imem_req), 32'h1);
        check("post_rst_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        check("post_rst_pc", pc_out, 32'h0);
        check("post_rst_inst", inst_out, 32'h100);
        check("post_rst_valid", 32'(valid_out), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
